uart_echo_initiator: RTL and testbench
======================================

Name: uart_echo_initiator

Overview:
Host-side initiator for the UART echo responder on the board. It generates a byte pattern, feeds it to a Tx serializer, and keeps each sent byte in an outstanding buffer. It compares every byte returned by the Rx deserializer against the buffer and reports pass/fail, error count and timeout. It sits between a Tx, an Rx and a Baud_Rate_Generator in a loopback bench or board top.

Parameters:
DATA_W, 8, byte width on the Tx/Rx data ports.
DEPTH, 8, outstanding-byte buffer entries; power of two.
LEN_W, 8, width of the message-length input.
TIMEOUT_TICKS, 2048, baud ticks allowed without a received byte while any byte is outstanding.

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run; ignored unless state is IDLE or DONE
msg_len  in  LEN_W  bytes to send; 0 = immediate DONE with pass=1
seed  in  DATA_W  first pattern byte
baud_tick  in  1  baud-rate tick from the generator
tx_busy  in  1  Tx serializer busy
tx_start  out  1  one-cycle launch pulse to Tx
tx_data  out  DATA_W  byte to Tx; held stable from the tx_start cycle until tx_busy falls
rx_ready  in  1  one-cycle strobe: rx_data valid
rx_data  in  DATA_W  received byte
busy  out  1  run in progress
done  out  1  level; high in DONE until the next start or rst
pass  out  1  valid while done: err_count==0 and no timeout
timeout  out  1  sticky for the run
err_count  out  8  mismatches plus unexpected bytes, saturating at 255

Behaviour:
- Reset: all outputs 0; tx_data=0; buffer empty; sent count 0; state IDLE. A reset mid-run aborts with no further tx_start.
- States: IDLE -> (start) SEND -> ... -> DONE. DONE -> (start) SEND, clearing counters, flags and buffer.
- SEND:
  - Issue tx_start when all hold: tx_busy=0, buffer not full, sent<msg_len, guard counter=0.
  - Same cycle: tx_data=pattern, push pattern into the buffer, sent++, advance pattern.
  - Guard: 2 cycles after each tx_start, during which tx_start cannot assert. This covers the Tx busy-assert latency.
  - When sent==msg_len, go to DRAIN.
- DRAIN: wait until the buffer is empty, then go to DONE.
- Timeout: checked in both SEND and DRAIN.
  - Counter increments on baud_tick while the buffer is non-empty.
  - Counter clears on rx_ready and whenever the buffer is empty.
  - Reaching TIMEOUT_TICKS: timeout=1, flush the buffer, go to DONE.
- On rx_ready in SEND or DRAIN:
  - Buffer non-empty: pop the head; if head != rx_data, err_count++.
  - Buffer empty: unexpected byte, err_count++, nothing popped.
  - rx_ready in IDLE/DONE: ignored.
- Push and pop in the same cycle: both take effect; occupancy unchanged. Push when full is impossible by the gating above.
- Pattern (default): byte i = seed + i, mod 2^DATA_W; 0xFF wraps to 0x00.
- err_count saturates at 255 and does not wrap.
- busy = state is SEND or DRAIN.
- pass is registered on entry to DONE.

Optional Feature:
UART_ECHO_LFSR_EN
- Defined: pattern is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. It is loaded with seed at start (seed 0x00 is replaced by 0x01) and advances once per sent byte.
- Undefined: incrementing pattern as above; no LFSR logic is present.

Decomposition:
- Package uart_echo_pkg: state encoding (IDLE, SEND, DRAIN, DONE), GUARD_CYCLES=2, LFSR tap mask 8'hB8, ERR_MAX=255.
- One sub-module, echo_fifo: synchronous DEPTH x DATA_W FIFO with push/pop/full/empty/flush and a same-cycle push+pop rule. The top holds the FSM, pattern generator and timeout counter.

Test Plan:
1. Loopback (tx wired through Tx/Rx), msg_len=16, seed=0x10 -> 16 tx_start pulses with data 0x10..0x1F; done=1, pass=1, err_count=0, timeout=0.
2. Loopback with bench corrupting echoed byte #3 (XOR 0x01), msg_len=8 -> done=1, pass=0, err_count=1.
3. Echo path cut after 2 bytes, msg_len=6 -> timeout=1 after 2048 baud ticks idle; done=1, pass=0; no tx_start after DONE.
4. Bench responder delays echoes until 8 outstanding, msg_len=20 -> tx_start stalls while the buffer is full and resumes on pop; pass=1.
5. seed=0xFE, msg_len=4, plus an extra injected rx_ready when the buffer is empty -> data 0xFE,0xFF,0x00,0x01; err_count=1.
6. rst asserted mid-SEND, then start with msg_len=0 -> all outputs clear the cycle after rst; second run goes straight to done=1, pass=1 with no tx_start.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo initiator.
// Optional LFSR pattern helper is built only with UART_ECHO_LFSR_EN.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int         GUARD_CYCLES = 2;
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] ERR_MAX      = 8'd255;

`ifdef UART_ECHO_LFSR_EN
    // Fibonacci step: feedback of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction
`endif

endpackage

// File: rtl/uart_echo_initiator_if.sv
// Bundle between the echo initiator and its Tx/Rx/baud environment.
// master: initiator side (drives tx_start/tx_data/status); slave: environment.
interface uart_echo_initiator_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  msg_len;
    logic [DATA_W-1:0] seed;
    logic              baud_tick;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [7:0]        err_count;

    modport master (
        input  start, msg_len, seed, baud_tick, tx_busy, rx_ready, rx_data,
        output tx_start, tx_data, busy, done, pass, timeout, err_count
    );

    modport slave (
        output start, msg_len, seed, baud_tick, tx_busy, rx_ready, rx_data,
        input  tx_start, tx_data, busy, done, pass, timeout, err_count
    );
endinterface

// File: rtl/uart_echo_initiator_echo_fifo.sv
// echo_fifo: synchronous DEPTH x DATA_W buffer of outstanding bytes.
// Ports: clk, rst, flush, push/push_data, pop/pop_data (head), full, empty.
module echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign do_pop   = pop && !empty;
    // A full buffer still accepts a push when the head leaves that cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/uart_echo_initiator.sv
// Echo initiator: sends a byte pattern to Tx, checks Rx echoes, flags timeout.
// Ports: clk, rst, bus (master: start/msg_len/seed in, tx/rx/status). LFSR: UART_ECHO_LFSR_EN.
module uart_echo_initiator
    import uart_echo_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 8,
    parameter int LEN_W         = 8,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_echo_initiator_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  sent_q, sent_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [1:0]        guard_q, guard_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        err_q, err_d;
    logic              timeout_q, timeout_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    logic active, rx_hit, err_inc, launch, tmo_fire;
    logic [DATA_W-1:0] pat_next, pat_init;

    echo_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (pat_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef UART_ECHO_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed starts at 1.
    assign pat_init = (bus.seed == '0) ? DATA_W'(1) : bus.seed;
    assign pat_next = DATA_W'(lfsr_next(8'(pat_q)));
`else
    assign pat_init = bus.seed;
    assign pat_next = pat_q + DATA_W'(1);
`endif

    assign active   = (state_q == ST_SEND) || (state_q == ST_DRAIN);
    assign rx_hit   = active && bus.rx_ready;
    assign fifo_pop = rx_hit && !fifo_empty;
    // Mismatch against the head, or a byte arriving with nothing outstanding.
    assign err_inc  = rx_hit && (fifo_empty || (fifo_head != bus.rx_data));
    assign launch   = (state_q == ST_SEND) && !bus.tx_busy && !fifo_full &&
                      (sent_q < len_q) && (guard_q == '0);
    assign tmo_fire = active && !fifo_empty && !rx_hit && bus.baud_tick &&
                      (tmo_q == TW'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sent_d     = sent_q;
        pat_d      = pat_q;
        guard_d    = guard_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        done_d     = done_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (err_inc && (err_q != ERR_MAX)) err_d = err_q + 8'd1;
        if (!active || fifo_empty || rx_hit) tmo_d = '0;
        else if (bus.baud_tick)              tmo_d = tmo_q + TW'(1);
        if (guard_q != '0) guard_d = guard_q - 2'd1;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    fifo_flush = 1'b1;
                    len_d      = bus.msg_len;
                    sent_d     = '0;
                    pat_d      = pat_init;
                    guard_d    = '0;
                    err_d      = '0;
                    timeout_d  = 1'b0;
                    if (bus.msg_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
            end
            ST_SEND: begin
                if (tmo_fire) begin
                    fifo_flush = 1'b1;
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    if (launch) begin
                        fifo_push  = 1'b1;
                        tx_start_d = 1'b1;
                        tx_data_d  = pat_q;
                        pat_d      = pat_next;
                        sent_d     = sent_q + LEN_W'(1);
                        guard_d    = 2'(GUARD_CYCLES);
                    end
                    if (sent_q == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tmo_fire) begin
                    fifo_flush = 1'b1;
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else if (fifo_empty) begin
                    pass_d  = (err_d == '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            sent_q     <= '0;
            pat_q      <= '0;
            guard_q    <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            pat_q      <= pat_d;
            guard_q    <= guard_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= (state_d == ST_SEND) || (state_d == ST_DRAIN);
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.timeout   = timeout_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_uart_echo_initiator.sv
// Bench for uart_echo_initiator: behavioural Tx/echo/Rx environment
// plus a reference of the expected byte stream and run outcome.
module tb_uart_echo_initiator;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int LEN_W     = 8;
    localparam int TMO       = 2048;
    localparam int BIT_TICKS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_echo_initiator_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    uart_echo_initiator #(
        .DATA_W        (DATA_W),
        .DEPTH         (DEPTH),
        .LEN_W         (LEN_W),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // environment configuration (set by the stimulus)
    int corrupt_idx = -1;
    int cut_after   = -1;
    int hold_n      = 0;
    int run_len     = 0;
    bit inject_req  = 0;
    bit env_clr     = 0;

    // environment state and observations
    logic [7:0] tx_log [$];
    logic [7:0] echo_q [$];
    logic [7:0] tx_byte, b;
    int n_tx, n_done_tx, n_echo, tx_cnt, gap, div;
    int max_out, tick_since_rx, stab_err, busy_start_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [7:0] sd, input int i);
`ifdef UART_ECHO_LFSR_EN
        logic [7:0] v;
        v = (sd == 8'h00) ? 8'h01 : sd;
        for (int k = 0; k < i; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
`else
        return 8'(int'(sd) + i);
`endif
    endfunction

    initial begin
        bus.baud_tick = 1'b0;
        bus.tx_busy   = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.rx_data   = '0;
    end

    // Tx serializer, echo responder and Rx strobe, all at the falling edge.
    always @(negedge clk) begin
        if (env_clr) begin
            tx_log.delete();
            echo_q.delete();
            n_tx = 0; n_done_tx = 0; n_echo = 0; tx_cnt = 0; gap = 0;
            max_out = 0; tick_since_rx = 0; stab_err = 0; busy_start_err = 0;
            bus.tx_busy = 1'b0;
            env_clr = 1'b0;
        end
        div = (div + 1) % 2;
        bus.baud_tick = (div == 0);
        if (bus.tx_start) begin
            if (bus.tx_busy) busy_start_err++;
            tx_log.push_back(bus.tx_data);
            n_tx++;
            tx_byte = bus.tx_data;
            bus.tx_busy = 1'b1;
            tx_cnt = BIT_TICKS;
        end else if (bus.tx_busy) begin
            if (bus.tx_data !== tx_byte) stab_err++;
            if (bus.baud_tick) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.tx_busy = 1'b0;
                    b = tx_byte;
                    if (n_done_tx == corrupt_idx) b = b ^ 8'h01;
                    if (cut_after < 0 || n_done_tx < cut_after) echo_q.push_back(b);
                    n_done_tx++;
                end
            end
        end
        if (n_tx - n_echo > max_out) max_out = n_tx - n_echo;
        bus.rx_ready = 1'b0;
        if (inject_req) begin
            bus.rx_ready = 1'b1;
            bus.rx_data  = 8'($urandom);
            inject_req   = 1'b0;
        end else if (gap > 0) begin
            gap--;
        end else if (echo_q.size() > 0 &&
                     (hold_n == 0 || n_tx - n_echo >= hold_n || n_tx == run_len)) begin
            bus.rx_ready = 1'b1;
            bus.rx_data  = echo_q.pop_front();
            n_echo++;
            gap = 1 + $urandom_range(0, 3);
        end
        if (bus.rx_ready) tick_since_rx = 0;
        else if (bus.baud_tick && !bus.done) tick_since_rx++;
    end

    task automatic clear_env();
        env_clr = 1'b1;
        step();
    endtask

    task automatic run(input logic [7:0] sd, input int len, input int corrupt,
                       input int cut, input int hold, input bit inject,
                       input bit exp_tmo);
        int n;
        int snap;
        int exp_err;
        bit exp_pass;
        clear_env();
        corrupt_idx = corrupt;
        cut_after   = cut;
        hold_n      = hold;
        run_len     = len;
        bus.seed    = sd;
        bus.msg_len = 8'(len);
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        if (inject) inject_req = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 20000) begin
            step();
            n++;
        end
        check("done", bus.done, 1'b1);
        snap = n_tx;
        repeat (30) step();
        exp_err  = (corrupt >= 0 ? 1 : 0) + (inject ? 1 : 0);
        exp_pass = (exp_err == 0) && !exp_tmo;
        check("busy_after_done", bus.busy, 1'b0);
        check("pass", bus.pass, exp_pass);
        check("timeout", bus.timeout, exp_tmo);
        check("err_count", bus.err_count, 32'(exp_err));
        check("tx_count", 32'(n_tx), 32'(len));
        check("no_tx_after_done", 32'(n_tx), 32'(snap));
        check("start_while_busy", 32'(busy_start_err), 0);
        check("tx_data_stable", 32'(stab_err), 0);
        for (int i = 0; i < tx_log.size() && i < len; i++)
            check($sformatf("tx_byte[%0d]", i), tx_log[i], ref_byte(sd, i));
        if (exp_tmo) check("timeout_ticks", 32'(tick_since_rx), 32'(TMO));
        if (hold > 0) check("max_outstanding", 32'(max_out), 32'(DEPTH));
    endtask

    initial begin
        int len;
        bus.start   = 1'b0;
        bus.msg_len = '0;
        bus.seed    = '0;
        rst = 1'b1;
        repeat (3) step();
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pass", bus.pass, 1'b0);
        check("rst_timeout", bus.timeout, 1'b0);
        check("rst_err", bus.err_count, 8'h00);
        rst = 1'b0;
        step();

        run(8'h10, 16, -1, -1, 0, 1'b0, 1'b0);
        run(8'h20, 8, 3, -1, 0, 1'b0, 1'b0);
        run(8'h33, 6, -1, 2, 0, 1'b0, 1'b1);
        run(8'h40, 20, -1, -1, 8, 1'b0, 1'b0);
        run(8'hFE, 4, -1, -1, 0, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 30);
            run(8'($urandom), len, (r == 1) ? $urandom_range(0, len - 1) : -1,
                -1, 0, 1'b0, 1'b0);
        end

        clear_env();
        corrupt_idx = -1; cut_after = -1; hold_n = 0; run_len = 20;
        bus.seed = 8'h77; bus.msg_len = 8'd20; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (60) step();
        check("mid_run_busy", bus.busy, 1'b1);
        rst = 1'b1;
        step();
        check("abort_tx_start", bus.tx_start, 1'b0);
        check("abort_tx_data", bus.tx_data, 8'h00);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_pass", bus.pass, 1'b0);
        check("abort_timeout", bus.timeout, 1'b0);
        check("abort_err", bus.err_count, 8'h00);
        rst = 1'b0;
        step();
        run(8'h5A, 0, -1, -1, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
